// File: rtl/sseg_pkg.sv
// Shared types, decode table and helpers for the four-digit seven-segment scanner.
package sseg_pkg;

    typedef logic [1:0] anode_idx_t;
    typedef logic [6:0] seg_t;

    // One displayable frame: four hex nibbles plus a per-digit enable mask.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  mask;
    } frame_t;

    localparam seg_t SSEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns, entry n is the glyph for hex value n.
    localparam seg_t [15:0] SSEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] frame_nibble(input logic [15:0] digits, input anode_idx_t idx);
        return digits[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// Hex nibble to active-low seven-segment pattern; purely combinational.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SSEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scanner.sv
// Four-digit multiplexed seven-segment scanner with a one-deep frame buffer;
// new frames take effect only at frame boundaries so a frame never tears.
module sseg_scanner
    import sseg_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned DIGIT_HZ = 1_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  load_en,
    output logic [6:0]  sseg,
    output logic [1:0]  anode_index,
    output logic        is_led_on,
    output logic        frame_tick
);

    localparam int unsigned TICKS = CLK_HZ / DIGIT_HZ;
    localparam int unsigned CNT_W = (TICKS < 2) ? 1 : $clog2(TICKS);
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICKS - 1);

    generate
        if (TICKS < 2) begin : g_ticks_check
            $error("sseg_scanner: CLK_HZ/DIGIT_HZ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] presc_q, presc_d;
    anode_idx_t       anode_q, anode_d;
    frame_t           active_q, active_d;
    frame_t           pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             load_ready_q, load_ready_d;
    logic             frame_tick_q, frame_tick_d;
    seg_t             sseg_q, sseg_d;
    logic             led_q, led_d;

    logic             step;
    logic             boundary;
    logic             transfer;
    logic [3:0]       cur_nibble;
    seg_t             cur_seg;

    always_comb begin : p_scan_next
        step         = (presc_q == PRESC_MAX);
        boundary     = step && (anode_q == 2'd0);
        presc_d      = step ? '0 : presc_q + CNT_W'(1);
        anode_d      = step ? anode_q - 2'd1 : anode_q;
        frame_tick_d = boundary;
    end

    always_comb begin : p_frame_next
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        transfer       = load_valid && load_ready_q;

        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end

        // Only reachable with pending empty, so it never races the promotion above.
        if (transfer) begin
            pending_d      = '{digits: load_digits, mask: load_en};
            pending_full_d = 1'b1;
        end

        load_ready_d = !pending_full_d;
    end

    // Look ahead to the next digit and next active frame so a freshly promoted
    // frame is visible on digit 3 in the very cycle after the boundary.
    assign cur_nibble = frame_nibble(active_d.digits, anode_d);

    sseg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_comb begin : p_out_next
        led_d  = active_d.mask[anode_d];
        sseg_d = led_d ? cur_seg : SSEG_BLANK;
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin : p_regs
        if (!rst_n) begin
            // NOTE: frame data is cleared too, so reset discards both shown and queued frames.
            presc_q        <= '0;
            anode_q        <= 2'd3;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            load_ready_q   <= 1'b0;
            frame_tick_q   <= 1'b0;
            sseg_q         <= SSEG_BLANK;
            led_q          <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            anode_q        <= anode_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            load_ready_q   <= load_ready_d;
            frame_tick_q   <= frame_tick_d;
            sseg_q         <= sseg_d;
            led_q          <= led_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign anode_index = anode_q;
    assign sseg        = sseg_q;
    assign is_led_on   = led_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_sseg_scanner.sv
// Bench for sseg_scanner: directed vector table, frame-buffer corner cases and
// randomized traffic, all checked against a cycle-count reference model.
module tb_sseg_scanner;

    localparam int CLK_HZ   = 1000;
    localparam int DIGIT_HZ = 100;
    localparam int TICKS    = CLK_HZ / DIGIT_HZ;
    localparam int FRAME    = 4 * TICKS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_digits = '0;
    logic [3:0]  load_en = '0;
    logic [6:0]  sseg;
    logic [1:0]  anode_index;
    logic        is_led_on;
    logic        frame_tick;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    sseg_scanner #(
        .CLK_HZ   (CLK_HZ),
        .DIGIT_HZ (DIGIT_HZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_en     (load_en),
        .sseg        (sseg),
        .anode_index (anode_index),
        .is_led_on   (is_led_on),
        .frame_tick  (frame_tick)
    );

    // Reference model: time is the number of running edges since reset,
    // accepted frames wait in a queue and one is promoted per frame boundary.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  mask;
    } tb_frame_t;

    tb_frame_t act_m;
    tb_frame_t pend_m[$];
    int        n_m = 0;
    logic      ready_m = 1'b0;
    bit        took_m = 1'b0;
    bit        bnd_m = 1'b0;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  mask;
        logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
        logic [3:0]  led;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [6:0] ref_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [1:0] exp_anode();
        return 2'(3 - ((n_m / TICKS) % 4));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        took_m = 1'b0;
        bnd_m  = 1'b0;
        if (!rst_n) begin
            n_m     = 0;
            act_m   = '0;
            pend_m.delete();
            ready_m = 1'b0;
        end else begin
            took_m = load_valid && ready_m;
            n_m++;
            bnd_m = (n_m % FRAME == 0);
            if (bnd_m && pend_m.size() > 0) act_m = pend_m.pop_front();
            if (took_m) pend_m.push_back('{digits: load_digits, mask: load_en});
            ready_m = (pend_m.size() == 0);
        end
    endtask

    task automatic compare_all();
        logic [1:0] a;
        logic       led;
        logic [6:0] s;
        a   = exp_anode();
        led = act_m.mask[a];
        s   = led ? ref_decode(act_m.digits[int'(a) * 4 +: 4]) : 7'b1111111;
        check("model_anode_index", anode_index, a);
        check("model_sseg", sseg, s);
        check("model_is_led_on", is_led_on, led);
        check("model_frame_tick", frame_tick, bnd_m);
        check("model_load_ready", load_ready, ready_m);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic load_frame(input logic [15:0] d, input logic [3:0] m);
        int guard = 0;
        load_valid  = 1'b1;
        load_digits = d;
        load_en     = m;
        do begin
            tick();
            guard++;
        end while (!took_m && guard < 3 * FRAME);
        load_valid = 1'b0;
        check("load_accept", took_m, 1);
    endtask

    task automatic wait_applied(input string tag);
        int guard = 0;
        while (pend_m.size() != 0 && guard < 3 * FRAME) begin
            tick();
            guard++;
        end
        check({tag, "_apply_timeout"}, pend_m.size() == 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        vecs[0] = '{16'h12AF, 4'hF,    {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
        vecs[1] = '{16'h8888, 4'b0101, {7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000}, 4'b0101};
        vecs[2] = '{16'hB3C5, 4'b1000, {7'b0000011, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b1000};
        vecs[3] = '{16'h6D7E, 4'b0110, {7'b1111111, 7'b0100001, 7'b1111000, 7'b1111111}, 4'b0110};
        vecs[4] = '{16'h0000, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, 4'b0000};
        vecs[5] = '{16'h9430, 4'hF,    {7'b0010000, 7'b0011001, 7'b0110000, 7'b1000000}, 4'b1111};

        // Reset and release.
        run(3);
        check("rst_anode", anode_index, 3);
        check("rst_sseg", sseg, 7'b1111111);
        check("rst_led", is_led_on, 0);
        check("rst_ready", load_ready, 0);
        rst_n = 1'b1;
        tick();
        check("release_ready", load_ready, 1);

        // Vector table: load, wait for the boundary, then check each digit's dwell.
        for (int i = 0; i < 6; i++) begin
            load_frame(vecs[i].digits, vecs[i].mask);
            wait_applied($sformatf("vec%0d", i));
            check($sformatf("vec%0d_tick", i), frame_tick, 1);
            for (int d = 3; d >= 0; d--) begin
                check($sformatf("vec%0d_d%0d_anode", i, d), anode_index, d);
                check($sformatf("vec%0d_d%0d_sseg", i, d), sseg, vecs[i].segs[d * 7 +: 7]);
                check($sformatf("vec%0d_d%0d_led", i, d), is_led_on, vecs[i].led[d]);
                run(TICKS);
            end
            check($sformatf("vec%0d_next_tick", i), frame_tick, 1);
        end

        // Back-to-back loads: the second stalls until the first is promoted.
        load_frame(16'h1234, 4'hF);
        check("b2b_ready_low", load_ready, 0);
        load_frame(16'h5678, 4'hF);
        check("b2b_first_frame", sseg, 7'b1111001);
        check("b2b_ready_low2", load_ready, 0);
        wait_applied("b2b");
        check("b2b_second_tick", frame_tick, 1);
        check("b2b_second_frame", sseg, 7'b0010010);

        // Load landing on the boundary edge is held until the following boundary.
        guard = 0;
        while ((n_m + 1) % FRAME != 0 && guard < FRAME) begin
            tick();
            guard++;
        end
        load_frame(16'hC0DE, 4'hF);
        check("bnd_load_tick", frame_tick, 1);
        check("bnd_load_ready", load_ready, 0);
        check("bnd_load_unchanged", sseg, 7'b0010010);
        wait_applied("bnd_load");
        check("bnd_load_applied", sseg, 7'b1000110);

        // Reset while on digit 1 with a frame queued.
        load_frame(16'hFFFF, 4'hF);
        guard = 0;
        while (exp_anode() != 2'd1 && guard < FRAME) begin
            tick();
            guard++;
        end
        check("mid_rst_on_digit1", anode_index, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_anode", anode_index, 3);
        check("mid_rst_sseg", sseg, 7'b1111111);
        check("mid_rst_led", is_led_on, 0);
        check("mid_rst_ready", load_ready, 0);
        check("mid_rst_tick", frame_tick, 0);
        rst_n = 1'b1;
        tick();
        check("mid_rst_release_ready", load_ready, 1);
        run(FRAME - 1);
        check("mid_rst_boundary_tick", frame_tick, 1);
        check("mid_rst_pending_gone", sseg, 7'b1111111);
        check("mid_rst_pending_led", is_led_on, 0);

        // Randomized traffic with occasional single-cycle resets.
        for (int c = 0; c < 1200; c++) begin
            rst_n       = ($urandom_range(0, 399) != 0);
            load_valid  = ($urandom_range(0, 3) == 0);
            load_digits = 16'($urandom);
            load_en     = 4'($urandom);
            tick();
        end
        rst_n      = 1'b1;
        load_valid = 1'b0;
        run(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/sseg_scanner.md
SSEG_SCANNER -- requirements
Module: sseg_scanner

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz, SHALL be used.
REQ-002 Parameter DIGIT_HZ, default 1_000, per-digit dwell rate in Hz, SHALL be used.
REQ-003 Port clk, input, 1, system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1, reset that SHALL be synchronous and active-low.
REQ-005 Port load_valid, input, 1, upstream offers a new frame.
REQ-006 Port load_ready, output, 1, block accepts a frame this cycle.
REQ-007 Port load_digits, input, 16, four hex nibbles; [15:12] = digit 3, [3:0] = digit 0.
REQ-008 Port load_en, input, 4, per-digit enable mask; bit n = digit n.
REQ-009 Port sseg, output, 7, active-low segments; bit0 = CA through bit6 = CG.
REQ-010 Port anode_index, output, 2, digit currently driven; feeds the board stage.
REQ-011 Port is_led_on, output, 1, current digit lit.
REQ-012 Port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-013 TICKS SHALL equal CLK_HZ/DIGIT_HZ, computed at elaboration; elaboration SHALL fail if TICKS < 2.
REQ-014 A prescaler SHALL count 0..TICKS-1 and wrap to 0.
REQ-015 On the edge where the prescaler equals TICKS-1, anode_index SHALL step in descending order, 3->2->1->0->3.
REQ-016 The step from 0 to 3 SHALL be the frame boundary; frame_tick SHALL be high for exactly that one cycle after the edge.
REQ-017 Block state: active register (digits + mask) and pending register (digits + mask + pending_full flag).
REQ-018 load_ready SHALL be registered and SHALL equal !pending_full.
REQ-019 A transfer SHALL occur when load_valid && load_ready; load_digits and load_en SHALL be captured into pending, and pending_full SHALL be set.
REQ-020 At a frame boundary with pending_full=1, pending SHALL copy to active and pending_full SHALL clear on the same edge.
REQ-021 A load and a boundary on the same edge with pending empty SHALL fill pending only; the new data SHALL be applied at the next boundary.
REQ-022 A boundary with pending empty SHALL leave active unchanged.
REQ-023 The displayed frame SHALL never mix two frames, i.e. no tearing mid-frame.
REQ-024 sseg, anode_index, is_led_on and frame_tick SHALL be registered, and all SHALL update on the same edge.
REQ-025 While the digit at anode_index is enabled in active: is_led_on SHALL be 1 and sseg SHALL be the decode of that nibble.
REQ-026 While that digit is disabled: is_led_on SHALL be 0 and sseg SHALL be 7'b1111111.
REQ-027 Decode (gfedcba, active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-028 Outputs SHALL refresh every cycle from active, so a change to active at a boundary SHALL be visible on digit 3 immediately.

Reset
REQ-029 While rst_n=0 at an edge: prescaler=0, anode_index=2'b11, is_led_on=0, sseg=7'b1111111, frame_tick=0.
REQ-030 While rst_n=0 at an edge: active digits=0, active mask=0, pending_full=0, load_ready=0.
REQ-031 load_ready SHALL go to 1 on the first edge after rst_n rises.
REQ-032 Reset asserted mid-frame SHALL discard both active and pending contents.

Structure
REQ-033 Package sseg_pkg SHALL hold the 16-entry decode table, constant SSEG_BLANK=7'b1111111, and an anode-index typedef (2-bit).
REQ-034 One combinational sub-module, sseg_decode (4-bit nibble in, 7-bit segments out), SHALL be instantiated once, driven from the active nibble selected by the next anode_index.

Verification (CLK_HZ=1000, DIGIT_HZ=100, so TICKS=10)
REQ-035 Reset then release -> anode_index=3, sseg=1111111, is_led_on=0; load_ready=1 one cycle after release.
REQ-036 Load 16'h12AF with mask 4'hF, then run 40 cycles after the first boundary -> anode_index 3,2,1,0 with 10 cycles each; sseg = 1111001, 0100100, 0001000, 0001110; frame_tick pulses every 40 cycles.
REQ-037 Load 16'h8888 with mask 4'b0101 -> digits 2 and 0 show 0000000 with is_led_on=1; digits 3 and 1 show 1111111 with is_led_on=0.
REQ-038 Two back-to-back loads within one frame -> second load stalls with load_ready=0 until the boundary; first frame displays in full, second frame displays after the next boundary.
REQ-039 Load asserted on the boundary edge -> accepted into pending; display unchanged until the following boundary.
REQ-040 rst_n pulsed low while on digit 1 -> next edge anode_index=3, sseg=1111111, pending cleared.
